// File: rtl/mac_switch_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mac_switch_pkg                                                    |
// | Shared types for the switch forwarding path: MAC width, group-bit |
// | position, learn result codes and the learn engine state encoding. |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package mac_switch_pkg;

  localparam int MAC_W     = 48;
  localparam int GROUP_BIT = 40;

  typedef logic [MAC_W-1:0] mac_t;

  typedef enum logic [2:0] {
    RES_REFRESH  = 3'd0,
    RES_MOVED    = 3'd1,
    RES_NEW      = 3'd2,
    RES_EVICTED  = 3'd3,
    RES_REJECTED = 3'd4
  } learn_result_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_WRITE = 2'd2
  } learn_state_e;

endpackage
`default_nettype wire

// File: rtl/mac_learn_engine_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mac_learn_if                                                      |
// | Learn request / completion handshake between ingress parsing and  |
// | the MAC learn engine.                                             |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface mac_learn_if #(
  parameter int NUM_PORTS   = 8,
  parameter int NUM_ENTRIES = 1024
);
  import mac_switch_pkg::*;

  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int IDX_W  = $clog2(NUM_ENTRIES);

  logic              learn_valid;
  logic              learn_ready;
  mac_t              learn_mac;
  logic [PORT_W-1:0] learn_port;
  logic              learn_done;
  learn_result_e     learn_result;
  logic [IDX_W-1:0]  learn_idx;

  modport master (
    output learn_valid, learn_mac, learn_port,
    input  learn_ready, learn_done, learn_result, learn_idx
  );

  modport slave (
    input  learn_valid, learn_mac, learn_port,
    output learn_ready, learn_done, learn_result, learn_idx
  );

endinterface
`default_nettype wire

// File: rtl/mac_learn_engine_victim_tracker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mac_victim_tracker                                                |
// | Running first-free index and minimum-hit victim index over a      |
// | table scan. Outputs already include the entry being sampled this  |
// | cycle, so the last scanned entry is visible when the scan ends.   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module mac_victim_tracker #(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             sample,
  input  logic [IDX_W-1:0] idx,
  input  logic             entry_valid,
  input  logic [IDX_W-1:0] hits,
  output logic             free_found,
  output logic [IDX_W-1:0] free_idx,
  output logic [IDX_W-1:0] victim_idx
);

  logic             free_q;
  logic [IDX_W-1:0] free_idx_q;
  logic             min_q;
  logic [IDX_W-1:0] min_hits_q;
  logic [IDX_W-1:0] min_idx_q;
  logic             take_free;
  logic             take_min;

  // First invalid entry wins; strict less-than keeps the lowest index on ties.
  assign take_free  = sample && !entry_valid && !free_q;
  assign take_min   = sample && entry_valid && (!min_q || (hits < min_hits_q));
  assign free_found = free_q || take_free;
  assign free_idx   = take_free ? idx : free_idx_q;
  assign victim_idx = take_min ? idx : min_idx_q;

  // Accumulate trackers across the scan; wiped while the engine is idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      free_q     <= 1'b0;
      free_idx_q <= '0;
      min_q      <= 1'b0;
      min_hits_q <= '0;
      min_idx_q  <= '0;
    end else if (clear) begin
      free_q     <= 1'b0;
      free_idx_q <= '0;
      min_q      <= 1'b0;
      min_hits_q <= '0;
      min_idx_q  <= '0;
    end else begin
      if (take_free) begin
        free_q     <= 1'b1;
        free_idx_q <= idx;
      end
      if (take_min) begin
        min_q      <= 1'b1;
        min_hits_q <= hits;
        min_idx_q  <= idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mac_learn_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mac_learn_engine                                                  |
// | Source-MAC learning: scans the MAC table one entry per cycle,     |
// | then refreshes, moves, inserts or evicts (lowest hit count) in a  |
// | single write cycle. Group MACs are rejected without a scan.       |
// | Optional aging: define MAC_LEARN_AGING_EN to add age_tick and     |
// | per-entry age flags.                                              |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module mac_learn_engine
  import mac_switch_pkg::*;
#(
  parameter int  NUM_PORTS   = 8,
  parameter int  NUM_ENTRIES = 1024,
  localparam int PORT_W      = $clog2(NUM_PORTS),
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                               clk,
  input  logic                               reset,
`ifdef MAC_LEARN_AGING_EN
  input  logic                               age_tick,
`endif
  mac_learn_if.slave                         learn,
  output logic [NUM_ENTRIES-1:0][MAC_W-1:0]  table_addresses,
  output logic [NUM_ENTRIES-1:0][PORT_W-1:0] table_ports,
  output logic [NUM_ENTRIES-1:0]             table_valid,
  input  logic [NUM_ENTRIES-1:0][IDX_W-1:0]  table_hits,
  output logic                               hit_clear,
  output logic [IDX_W-1:0]                   hit_clear_idx
);

  learn_state_e      state;
  logic [IDX_W-1:0]  idx;
  mac_t              mac_q;
  logic [PORT_W-1:0] port_q;
  logic              ready_q;
  logic              done_q;
  learn_result_e     result_q;
  logic [IDX_W-1:0]  out_idx;

  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic [IDX_W-1:0]  victim_idx;
  logic              entry_match;
  logic              last_entry;
  logic              age_hold;

`ifdef MAC_LEARN_AGING_EN
  logic [NUM_ENTRIES-1:0] age_flag;
  logic                   age_pending;
  // A pending or just-arriving tick keeps ready low so aging gets an idle slot.
  assign age_hold = age_pending || age_tick;
`else
  assign age_hold = 1'b0;
`endif

  assign entry_match = table_valid[idx] && (table_addresses[idx] == mac_q);
  assign last_entry  = (idx == IDX_W'(NUM_ENTRIES - 1));

  assign learn.learn_ready  = ready_q;
  assign learn.learn_done   = done_q;
  assign learn.learn_result = result_q;
  assign learn.learn_idx    = out_idx;

  mac_victim_tracker #(
    .IDX_W(IDX_W)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .clear      (state == ST_IDLE),
    .sample     (state == ST_SCAN),
    .idx        (idx),
    .entry_valid(table_valid[idx]),
    .hits       (table_hits[idx]),
    .free_found (free_found),
    .free_idx   (free_idx),
    .victim_idx (victim_idx)
  );

  // Learn FSM, table storage and aging; all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      idx             <= '0;
      mac_q           <= '0;
      port_q          <= '0;
      ready_q         <= 1'b0;
      done_q          <= 1'b0;
      result_q        <= RES_REFRESH;
      out_idx         <= '0;
      hit_clear       <= 1'b0;
      hit_clear_idx   <= '0;
      table_addresses <= '0;
      table_ports     <= '0;
      table_valid     <= '0;
`ifdef MAC_LEARN_AGING_EN
      age_flag        <= '0;
      age_pending     <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      hit_clear <= 1'b0;
`ifdef MAC_LEARN_AGING_EN
      if (age_tick) begin
        age_pending <= 1'b1;
      end
`endif
      case (state)
        ST_IDLE: begin
`ifdef MAC_LEARN_AGING_EN
          if (age_pending) begin
            // Entries not touched since the previous tick are dropped.
            table_valid <= table_valid & age_flag;
            age_flag    <= '0;
            age_pending <= age_tick;
            ready_q     <= !age_tick;
          end else
`endif
          if (learn.learn_valid && ready_q) begin
            mac_q   <= learn.learn_mac;
            port_q  <= learn.learn_port;
            ready_q <= 1'b0;
            if (learn.learn_mac[GROUP_BIT]) begin
              state    <= ST_WRITE;
              done_q   <= 1'b1;
              result_q <= RES_REJECTED;
              out_idx  <= '0;
            end else begin
              state <= ST_SCAN;
              idx   <= '0;
            end
          end else begin
            ready_q <= !age_hold;
          end
        end

        ST_SCAN: begin
          if (entry_match) begin
            state   <= ST_WRITE;
            done_q  <= 1'b1;
            out_idx <= idx;
            if (table_ports[idx] == port_q) begin
              result_q <= RES_REFRESH;
            end else begin
              result_q      <= RES_MOVED;
              hit_clear     <= 1'b1;
              hit_clear_idx <= idx;
            end
          end else if (last_entry) begin
            state     <= ST_WRITE;
            done_q    <= 1'b1;
            hit_clear <= 1'b1;
            if (free_found) begin
              result_q      <= RES_NEW;
              out_idx       <= free_idx;
              hit_clear_idx <= free_idx;
            end else begin
              result_q      <= RES_EVICTED;
              out_idx       <= victim_idx;
              hit_clear_idx <= victim_idx;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end

        ST_WRITE: begin
          // The whole table update lands on the edge that ends this cycle.
          case (result_q)
            RES_MOVED: begin
              table_ports[out_idx] <= port_q;
            end
            RES_NEW, RES_EVICTED: begin
              table_addresses[out_idx] <= mac_q;
              table_ports[out_idx]     <= port_q;
              table_valid[out_idx]     <= 1'b1;
            end
            default: begin
            end
          endcase
`ifdef MAC_LEARN_AGING_EN
          if (result_q != RES_REJECTED) begin
            age_flag[out_idx] <= 1'b1;
          end
`endif
          state   <= ST_IDLE;
          ready_q <= !age_hold;
        end

        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_learn_engine.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mac_learn_engine                                               |
// | Scoreboard bench: requests push expected completions predicted by |
// | a table model; a monitor pops and compares on learn_done.         |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_mac_learn_engine;

  localparam int N  = 4;
  localparam int NP = 8;

  typedef struct {
    int res;
    int idx;
    bit hc;
    int lat;
    int acc;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [N-1:0][47:0]   table_addresses;
  logic [N-1:0][2:0]    table_ports;
  logic [N-1:0]         table_valid;
  logic [N-1:0][1:0]    table_hits;
  logic                 hit_clear;
  logic [1:0]           hit_clear_idx;
`ifdef MAC_LEARN_AGING_EN
  logic                 age_tick = 1'b0;
`endif

  mac_learn_if #(.NUM_PORTS(NP), .NUM_ENTRIES(N)) learn();

  mac_learn_engine #(.NUM_PORTS(NP), .NUM_ENTRIES(N)) dut (
    .clk            (clk),
    .reset          (reset),
`ifdef MAC_LEARN_AGING_EN
    .age_tick       (age_tick),
`endif
    .learn          (learn),
    .table_addresses(table_addresses),
    .table_ports    (table_ports),
    .table_valid    (table_valid),
    .table_hits     (table_hits),
    .hit_clear      (hit_clear),
    .hit_clear_idx  (hit_clear_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  exp_t q[$];
  exp_t mon_e;

  // Reference table
  logic [47:0] m_mac[N];
  int          m_port[N];
  bit          m_valid[N];
  bit          m_age[N];
  logic [47:0] pool[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic void model_clear();
    for (int k = 0; k < N; k++) begin
      m_mac[k] = '0; m_port[k] = 0; m_valid[k] = 0; m_age[k] = 0;
    end
  endfunction

  function automatic void model_age_apply();
    for (int k = 0; k < N; k++) begin
      if (m_valid[k] && !m_age[k]) m_valid[k] = 0;
      m_age[k] = 0;
    end
  endfunction

  // Learning rules: reject group MACs, else match / lowest free / lowest-hit victim.
  function automatic exp_t predict(input logic [47:0] m, input int p);
    exp_t e;
    int best;
    e.res = 0; e.idx = 0; e.hc = 0; e.lat = 0; e.acc = 0;
    if (m[40]) begin
      e.res = 4; e.lat = 1;
      return e;
    end
    for (int k = 0; k < N; k++) begin
      if (m_valid[k] && m_mac[k] == m) begin
        e.idx = k; e.lat = k + 2; m_age[k] = 1;
        if (m_port[k] == p) e.res = 0;
        else begin e.res = 1; e.hc = 1; m_port[k] = p; end
        return e;
      end
    end
    e.lat = N + 1; e.hc = 1;
    for (int k = 0; k < N; k++) begin
      if (!m_valid[k]) begin
        e.res = 2; e.idx = k;
        m_valid[k] = 1; m_mac[k] = m; m_port[k] = p; m_age[k] = 1;
        return e;
      end
    end
    best = 0;
    for (int k = 1; k < N; k++) if (int'(table_hits[k]) < int'(table_hits[best])) best = k;
    e.res = 3; e.idx = best;
    m_mac[best] = m; m_port[best] = p; m_age[best] = 1;
    return e;
  endfunction

  task automatic chk_table();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("valid[%0d]", k), table_valid[k], m_valid[k]);
      if (m_valid[k]) begin
        chk($sformatf("mac[%0d]", k), table_addresses[k], m_mac[k]);
        chk($sformatf("port[%0d]", k), table_ports[k], m_port[k]);
      end
    end
  endtask

  // Issue one request (call at a negedge), wait for its completion, check the table.
  task automatic do_learn(input logic [47:0] m, input int p, input bit tick_in_scan);
    exp_t e;
    int w;
    w = 0;
    while (!learn.learn_ready && w < 200) begin @(negedge clk); w++; end
    if (!learn.learn_ready) begin
      chk("ready_timeout", learn.learn_ready, 1'b1);
      return;
    end
    learn.learn_valid = 1'b1;
    learn.learn_mac   = m;
    learn.learn_port  = 3'(p);
    e = predict(m, p);
    e.acc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    learn.learn_valid = 1'b0;
`ifdef MAC_LEARN_AGING_EN
    if (tick_in_scan) begin
      age_tick = 1'b1;
      @(negedge clk);
      age_tick = 1'b0;
    end
`endif
    w = 0;
    while (q.size() != 0 && w < 60) begin @(negedge clk); w++; end
    if (q.size() != 0) begin
      chk("done_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
    @(negedge clk);
    if (!tick_in_scan) chk_table();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    q.delete();
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      if (learn.learn_done) begin
        if (q.size() == 0) chk("unexpected_done", learn.learn_done, 1'b0);
        else begin
          mon_e = q.pop_front();
          chk("result", learn.learn_result, mon_e.res);
          chk("idx", learn.learn_idx, mon_e.idx);
          chk("latency", cyc - mon_e.acc + 1, mon_e.lat);
          chk("hit_clear", hit_clear, mon_e.hc);
          if (mon_e.hc) chk("hit_clear_idx", hit_clear_idx, mon_e.idx);
        end
      end else if (hit_clear) begin
        chk("stray_hit_clear", hit_clear, 1'b0);
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] m;
    learn.learn_valid = 1'b0;
    learn.learn_mac   = '0;
    learn.learn_port  = '0;
    table_hits        = '0;
    model_clear();
    for (int j = 0; j < 6; j++) begin
      m = {16'($urandom), 32'($urandom)};
      m[40] = 1'b0;
      pool[j] = m;
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", learn.learn_ready, 1'b0);
    chk("rst_done", learn.learn_done, 1'b0);
    chk("rst_result", learn.learn_result, 3'd0);
    chk("rst_idx", learn.learn_idx, 2'd0);
    chk("rst_hit_clear", hit_clear, 1'b0);
    chk("rst_hit_clear_idx", hit_clear_idx, 2'd0);
    chk("rst_table_valid", table_valid, 4'b0000);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_release", learn.learn_ready, 1'b1);

    // New, refresh, move
    do_learn(48'h001122334455, 3, 0);
    do_learn(48'h001122334455, 3, 0);
    do_learn(48'h001122334455, 6, 0);

    // Fill, then evict. Hit counters are 2 bits wide here, so the
    // {5,2,2,7} pattern saturates to {3,2,2,3}; entries 1 and 2 tie.
    do_learn(48'h0A0000000001, 1, 0);
    do_learn(48'h0A0000000002, 2, 0);
    do_learn(48'h0A0000000003, 4, 0);
    chk("full_valid", table_valid, 4'b1111);
    table_hits[0] = 2'd3; table_hits[1] = 2'd2; table_hits[2] = 2'd2; table_hits[3] = 2'd3;
    do_learn(48'h0B0000000009, 5, 0);

    // Group address rejected
    do_learn(48'h01005E000001, 2, 0);

    // Reset while scanning
    table_hits = '0;
    learn.learn_valid = 1'b1;
    learn.learn_mac   = 48'h0C0000000077;
    learn.learn_port  = 3'd1;
    @(negedge clk);
    learn.learn_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    model_clear();
    #1;
    chk("midrst_valid", table_valid, 4'b0000);
    chk("midrst_ready", learn.learn_ready, 1'b0);
    @(negedge clk);
    chk("midrst_done", learn.learn_done, 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst_ready_low", learn.learn_ready, 1'b0);
    @(negedge clk);
    chk("midrst_ready_high", learn.learn_ready, 1'b1);

    // Randomized traffic over a small MAC pool
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < N; k++) table_hits[k] = 2'($urandom_range(0, 3));
      m = pool[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) m[40] = 1'b1;
      do_learn(m, int'($urandom_range(0, NP - 1)), 0);
    end

`ifdef MAC_LEARN_AGING_EN
    // Aging: only entries refreshed since the first tick survive the second.
    do_reset();
    table_hits = '0;
    for (int k = 0; k < N; k++) do_learn(pool[k], k, 0);
    age_tick = 1'b1;
    @(negedge clk);
    age_tick = 1'b0;
    repeat (3) @(negedge clk);
    model_age_apply();
    chk("age1_valid", table_valid, 4'b1111);
    do_learn(pool[0], 0, 0);
    do_learn(pool[1], 1, 0);
    do_learn(pool[1], 1, 1);
    repeat (3) @(negedge clk);
    model_age_apply();
    chk_table();
    chk("age2_valid", table_valid, 4'b0011);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mac_learn_engine.md
Name: mac_learn_engine

Overview:
- Source-MAC learning stage of the switch forwarding path. Sits upstream of the lookup/read stage.
- Accepts (source MAC, ingress port) pairs from ingress parsing. Owns the MAC table storage (addresses, ports, valid bits).
- Inserts new entries, refreshes existing ones and evicts on full. Victim is the entry with the lowest hit count reported by the lookup stage.

Parameters:
- NUM_PORTS, 8, number of switch ports; PORT_W = $clog2(NUM_PORTS).
- NUM_ENTRIES, 1024, table depth; IDX_W = $clog2(NUM_ENTRIES).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- learn_valid  in  1  request valid.
- learn_ready  out  1  engine can accept a request.
- learn_mac  in  48  source MAC; bit 40 is the group (I/G) bit.
- learn_port  in  PORT_W  ingress port.
- learn_done  out  1  one-cycle pulse when a request completes.
- learn_result  out  3  0 REFRESH, 1 MOVED, 2 NEW, 3 EVICTED, 4 REJECTED; valid with learn_done.
- learn_idx  out  IDX_W  entry written or matched; valid with learn_done.
- table_addresses  out  48 x NUM_ENTRIES  stored MACs.
- table_ports  out  PORT_W x NUM_ENTRIES  stored ports.
- table_valid  out  NUM_ENTRIES  entry valid bits.
- table_hits  in  IDX_W x NUM_ENTRIES  hit counters from the lookup stage.
- hit_clear  out  1  one-cycle pulse; lookup stage zeroes table_hits[hit_clear_idx].
- hit_clear_idx  out  IDX_W  entry to clear.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All table arrays and valid bits are 0.
  - learn_ready=0, learn_done=0, learn_result=0, learn_idx=0, hit_clear=0, hit_clear_idx=0.
- learn_ready is registered. It is 1 in the first IDLE cycle after reset release. It drops the cycle after acceptance and returns in the cycle after learn_done.
- FSM states: IDLE, SCAN, WRITE.
- IDLE:
  - A handshake (valid & ready) captures mac and port.
  - If group bit = 1, go to WRITE with a reject flag and no scan.
  - Otherwise clear idx, clear the free/victim trackers, and go to SCAN.
- SCAN (one entry per cycle, idx 0..NUM_ENTRIES-1):
  - Valid entry with equal MAC: record match idx and go to WRITE immediately.
  - Invalid entry: record as free if no free entry is recorded yet, so the lowest free index wins.
  - Valid non-matching entry: track minimum table_hits. Strict less-than update, so on ties the lowest index wins.
  - At idx = NUM_ENTRIES-1 with no match, go to WRITE.
- WRITE (single cycle, learn_done=1, table update at end of cycle, then back to IDLE):
  - Match, same port: no table change; result REFRESH.
  - Match, different port: overwrite the port; result MOVED; hit_clear pulsed for that idx.
  - Free entry found: write MAC and port, set valid; result NEW; hit_clear pulsed.
  - Table full: overwrite the victim MAC and port; result EVICTED; hit_clear pulsed.
  - Reject flag set: no change; result REJECTED; learn_idx=0.
- Latency from the accept edge to learn_done:
  - Match at entry k: k+2 cycles.
  - Miss: NUM_ENTRIES+1 cycles.
  - Reject: 1 cycle.
- The lookup stage sees table arrays change only on the clock edge ending WRITE. There are no partial updates.
- Hit values are sampled during SCAN. Changes after an entry has been scanned are ignored for the current request.
- Reset mid-operation aborts the request with no learn_done and clears the table.
- Duplicate back-to-back requests are legal. The second returns REFRESH.

Optional Feature:
- Macro: MAC_LEARN_AGING_EN.
- When defined:
  - Adds input age_tick (1 bit) and a per-entry age flag.
  - The age flag is set on NEW, EVICTED, MOVED and REFRESH.
  - An age_tick pulse sets a sticky pending bit.
  - In an IDLE cycle with pending set, the engine applies aging instead of accepting a request (learn_ready=0 that cycle). Aging invalidates every valid entry whose age flag is 0, clears all age flags, and clears pending.
  - A tick arriving during SCAN or WRITE is held until the next IDLE cycle.
- When undefined: no age_tick port; entries persist until evicted or reset.

Decomposition:
- Shared package mac_switch_pkg holds:
  - MAC_W=48 and the group-bit position 40.
  - Enum learn_result_e.
  - FSM state enum.
  - mac_t typedef.
- One sub-module: mac_victim_tracker. Holds the running minimum hit value and index plus the first-free index, and clears on scan start. The FSM, table storage and aging stay in the top module.

Test Plan (NUM_ENTRIES=4, NUM_PORTS=8):
1. Empty table; learn 00:11:22:33:44:55 on port 3 -> learn_done after 5 cycles, result NEW, idx 0, valid=4'b0001, hit_clear idx 0.
2. Same MAC, port 3 -> REFRESH, idx 0, latency 2 cycles, no hit_clear. Same MAC, port 6 -> MOVED, table_ports[0]=6, hit_clear idx 0.
3. Fill 4 entries; hits={5,2,2,7}; learn a new MAC -> EVICTED, idx 1 (lowest index among ties), new MAC written to entry 1, hit_clear idx 1.
4. learn_mac=01:00:5E:00:00:01 (group bit set) -> REJECTED after 1 cycle, table unchanged.
5. Assert reset during SCAN -> no learn_done, all valid=0, learn_ready=0 then 1 one cycle after release.
6. (AGING_EN) Entries 0-1 refreshed after the first tick and entries 2-3 not; second tick during SCAN -> applied after WRITE, valid=4'b0011.
